// File: rtl/ltc2500_nyq_averager_pkg.sv
// Shared definitions for the LTC2500 Nyquist averaging path.
// These are the sample width, the largest window exponent, the derived
// accumulator width and the accumulator FSM state encoding. The controller
// and later stages use the same definitions.
package ltc2500_nyq_averager_pkg;

    localparam int DATA_W   = 20;
    localparam int LOG2_MAX = 10;
    localparam int ACC_W    = DATA_W + LOG2_MAX;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_ACCUM = 2'd2
    } state_t;

endpackage

// File: rtl/ltc2500_out_slot.sv
// Single-entry valid/ready holding register with overrun detection.
//
// Handshake: a result transfers to the consumer on any cycle where
// out_valid && out_ready. While out_valid=1 and out_ready=0, the payload
// does not change. A new result (load) is accepted when the slot is empty
// or is being popped in the same cycle. A pop and a load in the same cycle
// keep out_valid high, so there is no bubble. Otherwise the new result is
// dropped and overrun is set. Overrun is sticky. If clear_overrun and a
// drop happen in the same cycle, the drop wins.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   load, load_data/sum/log2_n   incoming result strobe and payload
//   out_ready                    consumer ready
//   clear_overrun                synchronous clear of the sticky flag
//   out_valid, out_data/sum/log2_n  held result
//   overrun                      sticky drop flag
module ltc2500_out_slot #(
    parameter int DATA_W = 20,
    parameter int ACC_W  = 30
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [ACC_W-1:0]  load_sum,
    input  logic [3:0]        load_log2_n,
    input  logic              out_ready,
    input  logic              clear_overrun,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ACC_W-1:0]  out_sum,
    output logic [3:0]        out_log2_n,
    output logic              overrun
);

    logic pop;
    logic accept;
    logic drop;

    assign pop    = out_valid && out_ready;
    assign accept = load && (!out_valid || out_ready);
    assign drop   = load && !accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sum    <= '0;
            out_log2_n <= '0;
            overrun    <= 1'b0;
        end else begin
            if (accept) begin
                out_valid  <= 1'b1;
                out_data   <= load_data;
                out_sum    <= load_sum;
                out_log2_n <= load_log2_n;
            end else if (pop) begin
                out_valid  <= 1'b0;
            end

            if (drop) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ltc2500_nyq_averager.sv
// Block averager for the LTC2500 Nyquist sample stream.
// It accumulates 2^log2_n consecutive samples. It then presents the floor
// average (arithmetic shift) and the raw sum through a single-entry
// valid/ready output slot.
//
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   enable           1 = accumulate, 0 = abort window and idle
//   log2_n           window exponent (clamped to LOG2_MAX)
//   in_valid/in_data sample strobe and signed sample
//   out_valid/out_ready/out_data/out_sum/out_log2_n  result interface
//   overrun/clear_overrun  sticky drop flag and its clear
//   sample_cnt       samples in the current window
//   fsm_state        accumulator state, exposed for observation
module ltc2500_nyq_averager
    import ltc2500_nyq_averager_pkg::*;
#(
    parameter int DATA_W   = ltc2500_nyq_averager_pkg::DATA_W,
    parameter int LOG2_MAX = ltc2500_nyq_averager_pkg::LOG2_MAX,
    parameter int ACC_W    = DATA_W + LOG2_MAX
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [3:0]          log2_n,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [ACC_W-1:0]    out_sum,
    output logic [3:0]          out_log2_n,
    output logic                overrun,
    input  logic                clear_overrun,
    output logic [LOG2_MAX:0]   sample_cnt,
    output state_t              fsm_state
);

    localparam int CNT_W = LOG2_MAX + 1;

    state_t                  state;
    state_t                  state_nxt;
    logic [3:0]              win_l2;
    logic [3:0]              l2_clamped;
    logic [3:0]              eff_l2;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum_nxt;
    logic signed [ACC_W-1:0] shifted;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    take;
    logic                    done;

    assign l2_clamped = (log2_n > 4'(LOG2_MAX)) ? 4'(LOG2_MAX) : log2_n;

    // The ARM cycle may already carry the first sample. At that point
    // win_l2 is still being latched, so it uses the clamped input directly.
    assign eff_l2 = (state == ST_ARM) ? l2_clamped : win_l2;

    assign take    = in_valid && enable && (state == ST_ARM || state == ST_ACCUM);
    assign sum_nxt = acc + {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    assign cnt_inc = sample_cnt + CNT_W'(1);
    assign done    = take && (cnt_inc == (CNT_W'(1) << eff_l2));
    assign shifted = sum_nxt >>> eff_l2;

    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable) state_nxt = ST_ARM;
            ST_ARM:   state_nxt = enable ? ST_ACCUM : ST_IDLE;
            ST_ACCUM: if (!enable) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            sample_cnt <= '0;
            win_l2     <= '0;
        end else if (!enable || state == ST_IDLE) begin
            acc        <= '0;
            sample_cnt <= '0;
        end else begin
            if (state == ST_ARM) begin
                win_l2 <= l2_clamped;
            end
            if (done) begin
                // Window boundary: start fresh and pick up any new window size.
                acc        <= '0;
                sample_cnt <= '0;
                win_l2     <= l2_clamped;
            end else if (take) begin
                acc        <= sum_nxt;
                sample_cnt <= cnt_inc;
            end
        end
    end

    ltc2500_out_slot #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_out_slot (
        .clk           (clk),
        .reset_n       (reset_n),
        .load          (done),
        .load_data     (shifted[DATA_W-1:0]),
        .load_sum      (sum_nxt),
        .load_log2_n   (eff_l2),
        .out_ready     (out_ready),
        .clear_overrun (clear_overrun),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_sum       (out_sum),
        .out_log2_n    (out_log2_n),
        .overrun       (overrun)
    );

endmodule
